// File: rtl/thor_l1_icache_ways.sv
// L1 instruction-cache way storage: two-stage fetch lookup, registered fill, line/all invalidate
// and victim selection (first invalid way, else LFSR).
module thor_l1_icache_ways #(
  parameter int          ABW       = 32,
  parameter int          SETS      = 64,
  parameter int          WAYS      = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [ABW-1:0] pc,
  input  logic           L1_selpc,
  input  logic [ABW-1:0] L1_adr,
  input  logic           L1_wr,
  input  logic [511:0]   L1_dat,
  input  logic [2:0]     L1_flt,
  input  logic           L1_invline,
  input  logic           invall,
  input  logic           icnxt,
  output logic           hit,
  output logic [127:0]   insn,
  output logic [2:0]     flt
);
  localparam int SETW = $clog2(SETS);
  localparam int TAGW = ABW - 6 - SETW;
  localparam int WW   = 2;

  logic [511:0]            data_q [WAYS][SETS];
  logic [TAGW-1:0]         tag_q  [WAYS][SETS];
  logic [2:0]              fltm_q [WAYS][SETS];
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;

  logic [ABW-1:0]  la_q;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            hit_q;
  logic [127:0]    insn_q;
  logic [2:0]      flt_q;

  // Pending fill: captured in the request cycle, written on the following edge.
  logic            wr_q, wr_d;
  logic [WW-1:0]   wr_way_q, victim;
  logic [SETW-1:0] wr_set_q;
  logic [TAGW-1:0] wr_tag_q;
  logic [511:0]    wr_dat_q;
  logic [2:0]      wr_flt_q;

  logic [SETW-1:0] req_set, la_set;
  logic [TAGW-1:0] req_tag, la_tag;
  logic            hit_c;
  logic [WW-1:0]   hit_way;
  logic [511:0]    hit_line;

  assign req_set = L1_adr[6+SETW-1:6];
  assign req_tag = L1_adr[ABW-1:6+SETW];
  assign la_set  = la_q[6+SETW-1:6];
  assign la_tag  = la_q[ABW-1:6+SETW];

  assign lfsr_d = icnxt ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;
  assign wr_d   = L1_wr & ~L1_invline & ~invall;

  always_comb begin
    victim = lfsr_q[WW-1:0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) victim = WW'(w);
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (wr_q) valid_d[wr_set_q][wr_way_q] = 1'b1;
    if (L1_invline) begin
      for (int w = 0; w < WAYS; w++) begin
        if (tag_q[w][req_set] == req_tag) valid_d[req_set][w] = 1'b0;
      end
    end
    if (invall) valid_d = '0;
  end

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit_c   = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[la_set][w] && tag_q[w][la_set] == la_tag) begin
        hit_c   = 1'b1;
        hit_way = WW'(w);
      end
    end
    hit_line = data_q[hit_way][la_set];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      wr_q    <= 1'b0;
      la_q    <= '0;
      lfsr_q  <= LFSR_SEED;
      hit_q   <= 1'b0;
      insn_q  <= '0;
      flt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      la_q    <= L1_selpc ? pc : L1_adr;
      lfsr_q  <= lfsr_d;
      hit_q   <= hit_c;
      if (hit_c) begin
        insn_q <= hit_line[{la_q[5:4], 7'd0} +: 128];
        flt_q  <= fltm_q[hit_way][la_set];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_d) begin
      wr_way_q <= victim;
      wr_set_q <= req_set;
      wr_tag_q <= req_tag;
      wr_dat_q <= L1_dat;
      wr_flt_q <= L1_flt;
    end
    if (wr_q && !rst_i) begin
      data_q[wr_way_q][wr_set_q] <= wr_dat_q;
      tag_q[wr_way_q][wr_set_q]  <= wr_tag_q;
      fltm_q[wr_way_q][wr_set_q] <= wr_flt_q;
    end
  end

  assign hit  = hit_q;
  assign insn = insn_q;
  assign flt  = flt_q;
endmodule

// File: tb/tb_thor_l1_icache_ways.sv
// Directed bench for thor_l1_icache_ways: lookup tables after fills, plus sequences for
// LFSR victim choice, line invalidate, invall/write collision and reset mid-fill.
module tb_thor_l1_icache_ways;
  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   pc, L1_adr;
  logic          L1_selpc, L1_wr, L1_invline, invall, icnxt;
  logic [511:0]  L1_dat;
  logic [2:0]    L1_flt;
  logic          hit;
  logic [127:0]  insn;
  logic [2:0]    flt;

  thor_l1_icache_ways dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc(pc), .L1_selpc(L1_selpc), .L1_adr(L1_adr),
    .L1_wr(L1_wr), .L1_dat(L1_dat), .L1_flt(L1_flt), .L1_invline(L1_invline),
    .invall(invall), .icnxt(icnxt), .hit(hit), .insn(insn), .flt(flt)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]  adr;
    bit           hit;
    logic [127:0] insn;
    logic [2:0]   flt;
  } vec_t;

  vec_t         tbl[$];
  int           n_chk = 0, n_fail = 0;
  logic [127:0] last_insn;
  logic [2:0]   last_flt;
  logic [15:0]  lfsr_m;
  logic [31:0]  evicted;
  logic [511:0] a5_line;

  function automatic logic [127:0] bundle(input logic [31:0] a, input int b);
    return {a, 32'(b), ~a, 32'hC0DE_0000 | 32'(b)};
  endfunction

  function automatic logic [511:0] gen_line(input logic [31:0] a);
    return {bundle(a, 3), bundle(a, 2), bundle(a, 1), bundle(a, 0)};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic fill(input logic [31:0] a, input logic [511:0] d, input logic [2:0] f);
    @(negedge clk_i);
    L1_adr = a; L1_dat = d; L1_flt = f; L1_wr = 1'b1;
    @(negedge clk_i);
    L1_wr = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic pulse_icnxt(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i); icnxt = 1'b1;
      @(negedge clk_i); icnxt = 1'b0;
      lfsr_m = lfsr_step(lfsr_m);
    end
  endtask

  // Present adr for one cycle, sample two edges later; misses expect held insn/flt.
  task automatic lookup(input string nm, input logic [31:0] a, input bit eh,
                        input logic [127:0] ei, input logic [2:0] ef);
    logic [127:0] xi;
    logic [2:0]   xf;
    @(negedge clk_i);
    L1_selpc = 1'b1; pc = a;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    xi = eh ? ei : last_insn;
    xf = eh ? ef : last_flt;
    n_chk++;
    if (hit !== eh) begin
      n_fail++;
      $display("FAIL %s hit adr=%h got=%b exp=%b", nm, a, hit, eh);
    end
    n_chk++;
    if (insn !== xi) begin
      n_fail++;
      $display("FAIL %s insn adr=%h got=%h exp=%h", nm, a, insn, xi);
    end
    n_chk++;
    if (flt !== xf) begin
      n_fail++;
      $display("FAIL %s flt adr=%h got=%0d exp=%0d", nm, a, flt, xf);
    end
    last_insn = xi;
    last_flt  = xf;
  endtask

  task automatic run_tbl(input string nm);
    foreach (tbl[i]) lookup(nm, tbl[i].adr, tbl[i].hit, tbl[i].insn, tbl[i].flt);
    tbl.delete();
  endtask

  task automatic add(input logic [31:0] a, input bit h, input logic [2:0] f);
    logic [31:0] base;
    base = {a[31:6], 6'd0};
    tbl.push_back('{adr: a, hit: h, insn: bundle(base, int'(a[5:4])), flt: f});
  endtask

  task automatic do_reset();
    @(negedge clk_i); rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    last_insn = '0; last_flt = '0; lfsr_m = 16'hACE1;
  endtask

  initial begin
    rst_i = 1'b1; pc = '0; L1_selpc = 1'b1; L1_adr = '0; L1_wr = 1'b0;
    L1_dat = '0; L1_flt = '0; L1_invline = 1'b0; invall = 1'b0; icnxt = 1'b0;
    do_reset();

    lookup("reset_miss", 32'hFFFC_0000, 1'b0, '0, 3'd0);

    a5_line = '0;
    a5_line[255:128] = {16{8'hA5}};
    a5_line[127:0]   = {16{8'h11}};
    a5_line[383:256] = {16{8'h22}};
    fill(32'hFFFC_0040, a5_line, 3'd0);
    lookup("fill_a5", 32'hFFFC_0050, 1'b1, {16{8'hA5}}, 3'd0);
    lookup("miss_holds", 32'hFFFC_0000, 1'b0, '0, 3'd0);

    for (int k = 1; k <= 4; k++) fill(32'h1000 * k, gen_line(32'h1000 * k), 3'd0);
    for (int k = 1; k <= 4; k++) add(32'h1000 * k + 32'h10 * (k - 1), 1'b1, 3'd0);
    run_tbl("four_ways");

    pulse_icnxt(3);
    evicted = 32'h1000 * (int'(lfsr_m[1:0]) + 1);
    fill(32'h5000, gen_line(32'h5000), 3'd0);
    for (int k = 1; k <= 5; k++) add(32'h1000 * k + 32'h30, (32'h1000 * k) != evicted, 3'd0);
    run_tbl("lfsr_victim");

    fill(32'h7040, gen_line(32'h7040), 3'd1);
    add(32'h7060, 1'b1, 3'd1);
    run_tbl("fault_fill");
    @(negedge clk_i); L1_adr = 32'h7040; L1_invline = 1'b1;
    @(negedge clk_i); L1_invline = 1'b0;
    lookup("invline_miss", 32'h7040, 1'b0, '0, 3'd0);
    lookup("invline_other", 32'hFFFC_0050, 1'b1, {16{8'hA5}}, 3'd0);

    @(negedge clk_i);
    L1_adr = 32'h8000; L1_dat = gen_line(32'h8000); L1_flt = 3'd0; L1_wr = 1'b1; invall = 1'b1;
    @(negedge clk_i); L1_wr = 1'b0; invall = 1'b0;
    repeat (2) @(negedge clk_i);
    add(32'h8000, 1'b0, 3'd0);
    add(32'h2000, 1'b0, 3'd0);
    add(32'hFFFC_0050, 1'b0, 3'd0);
    run_tbl("invall");

    fill(32'h9000, gen_line(32'h9000), 3'd0);
    pulse_icnxt(1);
    @(negedge clk_i);
    L1_adr = 32'hA000; L1_dat = gen_line(32'hA000); L1_wr = 1'b1;
    @(negedge clk_i); L1_wr = 1'b0; rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    last_insn = '0; last_flt = '0; lfsr_m = 16'hACE1;
    add(32'hA000, 1'b0, 3'd0);
    add(32'h9000, 1'b0, 3'd0);
    run_tbl("rst_midfill");

    for (int k = 1; k <= 5; k++) fill(32'h1000 * k + 32'h80, gen_line(32'h1000 * k + 32'h80), 3'd0);
    evicted = 32'h1000 * (int'(lfsr_m[1:0]) + 1) + 32'h80;
    for (int k = 1; k <= 5; k++)
      add(32'h1000 * k + 32'h80 + 32'h10 * (k % 4), (32'h1000 * k + 32'h80) != evicted, 3'd0);
    run_tbl("lfsr_reseed");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
